viterbi_link_ctrl: RTL

Frame sequencer and scoreboard for the encoder → channel → Viterbi decoder link. It feeds FRAME_LEN payload bits plus zero tail bits into the convolutional encoder and applies scheduled symbol-error injection on the channel path. It drives the decoder enable, aligns the sent bits with the decoder output, and counts injected symbol-bit flips and decoded bit errors per frame. It replaces free-running enables and ad hoc injection with a single controller that can run back-to-back frames.

---
 rtl/viterbi_pkg.sv | 20 ++
 rtl/viterbi_link_ctrl_if.sv | 18 +
 rtl/viterbi_ref_delay.sv | 19 +
 rtl/viterbi_link_ctrl.sv | 91 +++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared types, defaults and helpers for the Viterbi link controller
package viterbi_pkg;
  localparam int K = 3;
  localparam int TAIL_DEF = K - 1;
  localparam int FRAME_LEN_DEF = 256;
  localparam int N_DEF = 3;
  localparam int DEC_LAT_DEF = 64;
  localparam logic [1:0] ERR_MASK_DEF = 2'b01;
  typedef enum logic [2:0] {IDLE, RUN, FLUSH, DRAIN, DONE} link_state_t;
  typedef struct packed {
    logic valid;
    logic payload;
    logic dbit;
  } ref_entry_t;
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction
endpackage

// File: rtl/viterbi_link_ctrl_if.sv
// viterbi_link_ctrl_if: frame control, encoder, channel, decoder and scoreboard signals
interface viterbi_link_ctrl_if;
  logic start_i, inj_en_i, data_i, data_ready_o;
  logic enc_en_o, enc_bit_o, enc_valid_i;
  logic [1:0] enc_sym_i, chan_sym_o;
  logic dec_en_o, dec_bit_i, busy_o, done_o;
  logic [15:0] sym_err_ct_o, bit_err_ct_o;
  modport master (
    input start_i, inj_en_i, data_i, enc_valid_i, enc_sym_i, dec_bit_i,
    output data_ready_o, enc_en_o, enc_bit_o, chan_sym_o, dec_en_o, busy_o, done_o,
    sym_err_ct_o, bit_err_ct_o
  );
  modport slave (
    output start_i, inj_en_i, data_i, enc_valid_i, enc_sym_i, dec_bit_i,
    input data_ready_o, enc_en_o, enc_bit_o, chan_sym_o, dec_en_o, busy_o, done_o,
    sym_err_ct_o, bit_err_ct_o
  );
endinterface

// File: rtl/viterbi_ref_delay.sv
// viterbi_ref_delay: DEPTH-stage shift register of sent-bit reference entries
module viterbi_ref_delay
  import viterbi_pkg::*;
#(
  parameter int DEPTH = DEC_LAT_DEF + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  ref_entry_t d,
  output ref_entry_t q
);
  ref_entry_t [DEPTH-1:0] sr;
  // advance one stage per cycle; clr empties the line at frame start
  always_ff @(posedge clk or negedge rst)
    if (!rst) sr <= '0;
    else sr <= clr ? '0 : {sr[DEPTH-2:0], d};
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/viterbi_link_ctrl.sv
// viterbi_link_ctrl: frame sequencer, symbol-error injector and bit-error scoreboard for the Viterbi link
module viterbi_link_ctrl
  import viterbi_pkg::*;
#(
  parameter int         FRAME_LEN = FRAME_LEN_DEF,
  parameter int         TAIL      = TAIL_DEF,
  parameter int         N         = N_DEF,
  parameter logic [1:0] ERR_MASK  = ERR_MASK_DEF,
  parameter int         DEC_LAT   = DEC_LAT_DEF
) (
  input logic clk,
  input logic rst,
  viterbi_link_ctrl_if.master bus
);
  localparam int OW = $clog2(DEC_LAT + 4);
  link_state_t state, state_n;
  logic [16:0] bit_idx;
  logic [N-1:0] sym_idx;
  logic [OW-1:0] outst;
  logic inj_q, start, push, hit, miss;
  ref_entry_t ref_q, dl_q;
  assign start = state == IDLE && bus.start_i;
  assign push = state == RUN || state == FLUSH;
  assign hit = inj_q & bus.enc_valid_i & (sym_idx == '0);
  assign miss = dl_q.valid & dl_q.payload & (bus.dec_bit_i != dl_q.dbit);
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  // next-state: payload, then tail flush, then wait for the reference line to empty
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = bus.start_i ? RUN : IDLE;
      RUN:     state_n = bit_idx == 17'(FRAME_LEN - 1) ? (TAIL == 0 ? DRAIN : FLUSH) : RUN;
      FLUSH:   state_n = bit_idx == 17'(FRAME_LEN + TAIL - 1) ? DRAIN : FLUSH;
      DRAIN:   state_n = outst == '0 ? DONE : DRAIN;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // state-decoded outputs; the encoder sees the payload bit combinationally
  always_comb begin
    bus.data_ready_o = state == RUN;
    bus.enc_en_o = push;
    bus.enc_bit_o = state == RUN && bus.data_i;
    bus.busy_o = state != IDLE;
    bus.done_o = state == DONE;
  end
  // frame bookkeeping; ref_q stands in for the one-cycle encoder latency
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bit_idx <= '0;
      inj_q <= 1'b0;
      ref_q <= '0;
      outst <= '0;
    end else begin
      bit_idx <= start ? '0 : bit_idx + 17'(push);
      inj_q <= start ? bus.inj_en_i : inj_q;
      ref_q <= '{valid: push, payload: state == RUN, dbit: bus.enc_bit_o};
      outst <= start ? '0 : outst + OW'(push) - OW'(dl_q.valid);
    end
  // first stage rides alongside chan_sym_o, so DEC_LAT more stages reach the decoder output
  viterbi_ref_delay #(.DEPTH(DEC_LAT + 1)) u_dly (
    .clk(clk),
    .rst(rst),
    .clr(start),
    .d(ref_q),
    .q(dl_q)
  );
  // channel stage: register the symbol and corrupt every 2^N-th one of the frame
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.dec_en_o <= 1'b0;
      bus.chan_sym_o <= 2'b00;
      sym_idx <= '0;
    end else begin
      bus.dec_en_o <= bus.enc_valid_i;
      bus.chan_sym_o <= bus.enc_sym_i ^ (hit ? ERR_MASK : 2'b00);
      sym_idx <= start ? '0 : sym_idx + N'(bus.enc_valid_i);
    end
  // saturating per-frame error counters, cleared on start and held otherwise
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.sym_err_ct_o <= '0;
      bus.bit_err_ct_o <= '0;
    end else begin
      bus.sym_err_ct_o <= start ? '0 : hit ? sat_add(bus.sym_err_ct_o, 16'($countones(ERR_MASK))) : bus.sym_err_ct_o;
      bus.bit_err_ct_o <= start ? '0 : miss ? sat_add(bus.bit_err_ct_o, 16'd1) : bus.bit_err_ct_o;
    end
endmodule
